// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encoding and count-width helper.
package shift_reg_pkg;

  typedef logic [1:0] shift_mode_t;

  localparam shift_mode_t MODE_HOLD = 2'b00;
  localparam shift_mode_t MODE_SHR  = 2'b01;
  localparam shift_mode_t MODE_SHL  = 2'b10;
  localparam shift_mode_t MODE_LOAD = 2'b11;

  // Width of a counter that holds 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_word_counter.sv
// Counts shifts within a word and emits a registered word_done pulse on every WIDTH-th shift.
module shift_word_counter
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         shift_pulse,
  input  logic                         clear,
  output logic [cnt_width(WIDTH)-1:0]  bit_cnt,
  output logic                         word_done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          word_done_q, word_done_d;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    word_done_d = 1'b0;
    if (clear) begin
      bit_cnt_d = '0;
    end else if (shift_pulse) begin
      // The wrapping shift is also bit 1 of nothing: it closes the word.
      if (bit_cnt_q == LAST_CNT) begin
        bit_cnt_d   = '0;
        word_done_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      word_done_q <= word_done_d;
    end
  end

  assign bit_cnt   = bit_cnt_q;
  assign word_done = word_done_q;

endmodule

// File: rtl/univ_shift_register.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / load) with word counter.
// Optional even-parity output enabled by defining UNIV_SHIFT_REGISTER_PARITY_EN.
module univ_shift_register
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic                         serial_in_r,
  input  logic                         serial_in_l,
  input  logic [WIDTH-1:0]             parallel_in,
  output logic [WIDTH-1:0]             parallel_out,
  output logic                         serial_out_r,
  output logic                         serial_out_l,
  output logic [cnt_width(WIDTH)-1:0]  bit_cnt,
  output logic                         word_done,
  output logic                         parity
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             shift_pulse;
  logic             clear;
  shift_mode_t      mode_s;

  assign mode_s = shift_mode_t'(mode);

  always_comb begin
    q_d         = q_q;
    shift_pulse = 1'b0;
    clear       = 1'b0;
    if (en) begin
      case (mode_s)
        MODE_SHR: begin
          q_d         = {serial_in_r, q_q[WIDTH-1:1]};
          shift_pulse = 1'b1;
        end
        MODE_SHL: begin
          q_d         = {q_q[WIDTH-2:0], serial_in_l};
          shift_pulse = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = parallel_in;
          clear = 1'b1;
        end
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= RESET_VAL;
    else       q_q <= q_d;
  end

  shift_word_counter #(.WIDTH(WIDTH)) u_counter (
    .clk         (clk),
    .reset       (reset),
    .shift_pulse (shift_pulse),
    .clear       (clear),
    .bit_cnt     (bit_cnt),
    .word_done   (word_done)
  );

  assign parallel_out = q_q;
  assign serial_out_r = q_q[0];
  assign serial_out_l = q_q[WIDTH-1];

`ifdef UNIV_SHIFT_REGISTER_PARITY_EN
  assign parity = ^q_q;
`else
  assign parity = 1'b0;
`endif

endmodule

// File: doc/univ_shift_register.md
Name: univ_shift_register

Overview:
Parametrised successor to the team's serial-in/serial-out shift register. It is a WIDTH-bit universal shift register with four modes: hold, shift right, shift left and parallel load. It adds shift enable, serial outputs at both ends, full parallel output, and a shift counter that pulses word_done after every WIDTH shifts. It is used as the framing/serialiser building block for the serial links in the design.

Parameters:
WIDTH, 8, register width in bits; legal range 2..64.
RESET_VAL, {WIDTH{1'b0}}, value loaded into the register on reset.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  operation enable; when 0 the mode input is ignored and all state holds.
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
serial_in_r  input  1  bit entering the MSB on a right shift.
serial_in_l  input  1  bit entering the LSB on a left shift.
parallel_in  input  WIDTH  data loaded when mode=11.
parallel_out  output  WIDTH  current register contents (q).
serial_out_r  output  1  q[0]; the bit leaving on the next right shift.
serial_out_l  output  1  q[WIDTH-1]; the bit leaving on the next left shift.
bit_cnt  output  clog2(WIDTH)  number of shifts since the last load, reset or wrap.
word_done  output  1  registered one-cycle pulse.
parity  output  1  see Optional Feature.

Behaviour:
- Reset (clk edge with reset=1) has priority over everything:
  - q <= RESET_VAL, bit_cnt <= 0, word_done <= 0.
  - Reset asserted mid-word discards any partial count.
- en=0 or mode=00: q, bit_cnt hold; word_done <= 0.
- mode=01 (shift right): q <= {serial_in_r, q[WIDTH-1:1]}.
- mode=10 (shift left): q <= {q[WIDTH-2:0], serial_in_l}.
- Shift counter, applied on any shift (mode 01 or 10 with en=1):
  - If bit_cnt == WIDTH-1: bit_cnt <= 0 and word_done <= 1.
  - Otherwise: bit_cnt <= bit_cnt+1 and word_done <= 0.
- word_done timing: it is high in the same cycle parallel_out first shows the completed word (1 cycle after the WIDTH-th shifting edge).
- Direction change mid-word does not reset the counter; left and right shifts both count.
- mode=11 (parallel load): q <= parallel_in, bit_cnt <= 0, word_done <= 0; any partial count is discarded.
- serial_out_r and serial_out_l are combinational from q. No combinational path from inputs to outputs.
- Back-to-back words: a shift on the word_done cycle counts as bit 1 of the next word. Continuous shifting therefore gives word_done every WIDTH cycles exactly.

Optional Feature:
Macro: UNIV_SHIFT_REGISTER_PARITY_EN.
- Defined: parity = ^q, i.e. the even-parity bit of the current contents (combinational from q).
- Undefined: parity is tied to 0 and no XOR tree is synthesised.
- The port list is identical in both builds.

Decomposition:
- Shared package shift_reg_pkg holds:
  - the mode encoding constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD;
  - a 2-bit shift_mode_t typedef;
  - a clog2-based count-width function.
- One natural sub-module, shift_word_counter: owns bit_cnt and word_done, with inputs shift_pulse and clear and parameter WIDTH. The datapath stays in the top module.

Test Plan:
1. Reset held 2 cycles with WIDTH=8 -> parallel_out=8'h00, bit_cnt=0, word_done=0, serial outputs 0.
2. en=1, mode=01, serial_in_r driven 1,0,1,0,0,0,1,1 over 8 cycles -> parallel_out=8'hC5 and word_done=1 for exactly that one cycle; bit_cnt=0 afterwards.
3. Load 8'hA5, then mode=10 with serial_in_l=0 for 4 cycles -> serial_out_l reads 1,0,1,0 before each shift; final parallel_out=8'h50, bit_cnt=4, no word_done.
4. mode=01 held with en=0 for 5 cycles after loading 8'h3C -> parallel_out stays 8'h3C, bit_cnt stays 0.
5. Three right shifts, then reset=1 for 1 cycle, then 8 further shifts -> word_done only after the 8th post-reset shift, never at shift 5.
6. Five shifts, then load 8'h07 -> bit_cnt=0, no word_done. parity=1 with the macro defined and 0 without; after loading 8'h3C, parity=0 in both builds.
